multicycle_control: RTL and testbench

- Multicycle sequencer for the MIPS datapath; one instruction executes over 3–5 states plus memory wait cycles.
- Drives the shared ALU, the single unified memory port (with a ready handshake), the IR and PC write enables, the register file, and the PC source mux.
- Supports R-type, lw/lb/lh, sw/sb/sh, beq, j, addi/andi/ori/slti, a halt request and a retired-instruction counter.

---
 rtl/multicycle_control.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS control sequencer: one registered state per datapath phase,
// with controls decoded from the current state and the IR opcode.
module multicycle_control #(
    parameter int COUNT_W = 32
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic [5:0]         Opcode,
    input  logic               MemReady,
    input  logic               Halt,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic [1:0]         MemSize,
    output logic               IllegalOp,
    output logic               Halted,
    output logic [COUNT_W-1:0] InstrCount,
    output logic [3:0]         DbgState
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_RWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_TRAP
    } state_e;

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q;
    logic               is_load;
    logic [1:0]         mem_size;
    state_e             end_state;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && MemReady)
                count_q <= count_q + CNT_ONE;
        end
    end

    assign InstrCount = count_q;
    assign DbgState   = state_q;
    assign is_load    = (Opcode == OP_LW) || (Opcode == OP_LB) || (Opcode == OP_LH);
    // Halt only takes effect at an instruction boundary.
    assign end_state  = Halt ? S_IDLE : S_FETCH;

    always_comb begin
        mem_size = 2'b00;
        case (Opcode)
            OP_LH, OP_SH: mem_size = 2'b01;
            OP_LB, OP_SB: mem_size = 2'b10;
            default:      mem_size = 2'b00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        MemSize     = 2'b00;
        IllegalOp   = 1'b0;
        Halted      = 1'b0;
        case (state_q)
            S_IDLE: begin
                Halted = 1'b1;
                if (!Halt) state_d = S_FETCH;
            end
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = MemReady;
                IRWrite = MemReady;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_RTYPE:                              state_d = S_EXEC;
                    OP_LW, OP_LB, OP_LH, OP_SW, OP_SB, OP_SH: state_d = S_MEMADR;
                    OP_BEQ:                                state_d = S_BRANCH;
                    OP_J:                                  state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:     state_d = S_IEXEC;
                    default:                               state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = is_load ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                MemSize = mem_size;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = end_state;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                MemSize  = mem_size;
                if (MemReady) state_d = end_state;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = end_state;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
                state_d = S_IWB;
            end
            S_IWB: begin
                RegWrite = 1'b1;
                state_d  = end_state;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = end_state;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = end_state;
            end
            S_TRAP: begin
                IllegalOp = 1'b1;
                state_d   = end_state;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a per-instruction step-list model predicts every
// cycle's controls and the fetch counter; literal expectations pin the model.
module tb_multicycle_control;
  localparam int CW = 8;

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic [5:0]    Opcode = 6'd0;
  logic          MemReady = 1'b0;
  logic          Halt = 1'b0;
  logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic          MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp, Halted;
  logic [1:0]    ALUSrcB, ALUOp, PCSource, MemSize;
  logic [CW-1:0] InstrCount;
  logic [3:0]    DbgState;

  multicycle_control #(.COUNT_W(CW)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Opcode(Opcode), .MemReady(MemReady), .Halt(Halt),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .MemSize(MemSize), .IllegalOp(IllegalOp), .Halted(Halted),
    .InstrCount(InstrCount), .DbgState(DbgState)
  );

  // clock / reset
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source, mem_size;
    logic       illegal_op, halted;
  } ctl_t;

  typedef struct packed {
    ctl_t c;
    logic wait_mem;
    logic fetch;
  } step_t;

  ctl_t act;
  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, MemSize, IllegalOp, Halted};

  // model state
  step_t         steps[$];
  logic [5:0]    forced_q[$];
  logic [5:0]    cur_op = 6'd0;
  bit            m_idle = 1'b1;
  logic [CW-1:0] m_count = '0;
  logic [5:0]    valid_ops[13] = '{6'b000000, 6'b100011, 6'b100000, 6'b100001, 6'b101011,
                                   6'b101000, 6'b101001, 6'b000100, 6'b000010, 6'b001000,
                                   6'b001100, 6'b001101, 6'b001010};

  int            n_checks = 0;
  int            n_pass = 0;
  ctl_t          last_act;
  logic [CW-1:0] last_cnt;
  int            rd_cycles;

  // scoreboard
  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h (state %0d, t=%0t)", name, got, want, DbgState, $time);
  endtask

  task automatic push_step(input ctl_t c, input logic w, input logic f);
    step_t s;
    s.c = c; s.wait_mem = w; s.fetch = f;
    steps.push_back(s);
  endtask

  task automatic load_instr();
    ctl_t c;
    logic [1:0] sz;
    if (forced_q.size() > 0) cur_op = forced_q.pop_front();
    else if ($urandom_range(0, 3) == 0) cur_op = 6'($urandom_range(0, 63));
    else cur_op = valid_ops[$urandom_range(0, 12)];
    // word when low bits 11, half when 01, byte when 00
    sz = (cur_op[1:0] == 2'b11) ? 2'b00 : (cur_op[1:0] == 2'b01) ? 2'b01 : 2'b10;
    steps.delete();
    c = '0; c.mem_read = 1; c.alu_src_b = 2'b01;
    push_step(c, 1'b1, 1'b1);
    c = '0; c.alu_src_b = 2'b11;
    push_step(c, 1'b0, 1'b0);
    if (cur_op inside {6'b100011, 6'b100000, 6'b100001}) begin
      c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10;             push_step(c, 1'b0, 1'b0);
      c = '0; c.mem_read = 1; c.iord = 1; c.mem_size = sz;       push_step(c, 1'b1, 1'b0);
      c = '0; c.reg_write = 1; c.mem_to_reg = 1;                 push_step(c, 1'b0, 1'b0);
    end else if (cur_op inside {6'b101011, 6'b101000, 6'b101001}) begin
      c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10;             push_step(c, 1'b0, 1'b0);
      c = '0; c.mem_write = 1; c.iord = 1; c.mem_size = sz;      push_step(c, 1'b1, 1'b0);
    end else if (cur_op == 6'b000000) begin
      c = '0; c.alu_src_a = 1; c.alu_op = 2'b10;                 push_step(c, 1'b0, 1'b0);
      c = '0; c.reg_write = 1; c.reg_dst = 1;                    push_step(c, 1'b0, 1'b0);
    end else if (cur_op inside {6'b001000, 6'b001100, 6'b001101, 6'b001010}) begin
      c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; push_step(c, 1'b0, 1'b0);
      c = '0; c.reg_write = 1;                                   push_step(c, 1'b0, 1'b0);
    end else if (cur_op == 6'b000100) begin
      c = '0; c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01;
      push_step(c, 1'b0, 1'b0);
    end else if (cur_op == 6'b000010) begin
      c = '0; c.pc_write = 1; c.pc_source = 2'b10;               push_step(c, 1'b0, 1'b0);
    end else begin
      c = '0; c.illegal_op = 1;                                  push_step(c, 1'b0, 1'b0);
    end
  endtask

  task automatic model_expect(input logic mr, output ctl_t e);
    e = '0;
    if (m_idle) e.halted = 1;
    else begin
      e = steps[0].c;
      if (steps[0].fetch) begin e.pc_write = mr; e.ir_write = mr; end
    end
  endtask

  task automatic model_advance(input logic mr, input logic h);
    if (m_idle) begin
      if (!h) begin m_idle = 1'b0; load_instr(); end
    end else begin
      if (steps[0].fetch && mr) m_count = m_count + 1'b1;
      if (!steps[0].wait_mem || mr) begin
        void'(steps.pop_front());
        if (steps.size() == 0) begin
          if (h) m_idle = 1'b1;
          else load_instr();
        end
      end
    end
  endtask

  // driver: one clock cycle of stimulus plus the per-cycle comparison
  task automatic cycle(input logic mr, input logic h);
    ctl_t e;
    @(negedge Clock);
    MemReady = mr; Halt = h; Opcode = cur_op;
    #1;
    model_expect(mr, e);
    check_val("ctl", 32'(act), 32'(e));
    check_val("instr_count", 32'(InstrCount), 32'(m_count));
    last_act = act;
    last_cnt = InstrCount;
    model_advance(mr, h);
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset_n = 1'b0; MemReady = 1'b1; Halt = 1'b0;
    #1;
    check_val("reset_ctl", 32'(act), 32'h00001);
    check_val("reset_count", 32'(InstrCount), 32'd0);
    m_idle = 1'b1; m_count = '0; steps.delete();
    @(posedge Clock);
    #1 Reset_n = 1'b1;
  endtask

  initial begin
    logic mr, h;
    do_reset();

    // directed: R-type, lw with waits, sb, beq, j, illegal, addi with halt
    forced_q = '{6'b000000, 6'b100011, 6'b101000, 6'b000100, 6'b000010, 6'b111111, 6'b001000};
    rd_cycles = 0;
    for (int i = 0; i < 34; i++) begin
      mr = !(i inside {5, 6, 10, 11, 12});
      h  = (i inside {30, 31, 32});
      cycle(mr, h);
      if (i >= 5 && i <= 14 && last_act.mem_read) rd_cycles++;
      case (i)
        0:  check_val("idle_ctl", 32'(last_act), 32'h00001);
        4:  begin
              check_val("rwb_ctl", 32'(last_act), 32'h01800);
              check_val("rwb_count", 32'(last_cnt), 32'd1);
            end
        5:  check_val("fetch_wait_ctl", 32'(last_act), 32'h10100);
        7:  check_val("fetch_ready_ctl", 32'(last_act), 32'h94100);
        10: check_val("memrd_wait_ctl", 32'(last_act), 32'h30000);
        14: begin
              check_val("memwb_ctl", 32'(last_act), 32'h02800);
              check_val("lw_memread_cycles", 32'(rd_cycles), 32'd7);
              check_val("lw_count", 32'(last_cnt), 32'd2);
            end
        18: check_val("memwr_sb_ctl", 32'(last_act), 32'h28008);
        21: check_val("branch_ctl", 32'(last_act), 32'h40450);
        24: begin
              check_val("jump_ctl", 32'(last_act), 32'h80020);
              check_val("jump_count", 32'(last_cnt), 32'd5);
            end
        27: check_val("trap_ctl", 32'(last_act), 32'h00002);
        31: check_val("iwb_ctl", 32'(last_act), 32'h00800);
        32: check_val("halted_ctl", 32'(last_act), 32'h00001);
        default: ;
      endcase
    end

    // randomized traffic; the narrow counter wraps several times
    for (int i = 0; i < 3000; i++) begin
      mr = ($urandom_range(0, 3) != 0);
      h  = ($urandom_range(0, 11) == 0);
      cycle(mr, h);
    end

    // asynchronous reset in the middle of a stalled store
    do_reset();
    forced_q = '{6'b101000};
    for (int i = 0; i < 5; i++) cycle((i == 4) ? 1'b0 : 1'b1, 1'b0);
    check_val("memwr_before_reset", 32'(MemWrite), 32'd1);
    Reset_n = 1'b0;
    #1;
    check_val("async_reset_ctl", 32'(act), 32'h00001);
    check_val("async_reset_count", 32'(InstrCount), 32'd0);
    m_idle = 1'b1; m_count = '0; steps.delete();
    @(posedge Clock);
    #1 Reset_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      mr = ($urandom_range(0, 3) != 0);
      h  = ($urandom_range(0, 15) == 0);
      cycle(mr, h);
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
